// File: rtl/deit_tile_feeder_if.sv
// Bundles the host write port and the core streaming port of the tile feeder.
// The master side is the host/core (drives requests), the slave side is the feeder.
interface deit_tile_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_ROW  = 16,
  parameter int ARRAY_COL  = 16,
  parameter int W_DEPTH    = 12,
  parameter int IN_DEPTH   = 16
);
  localparam int MAX_DEPTH = (W_DEPTH > IN_DEPTH) ? W_DEPTH : IN_DEPTH;
  localparam int ADDR_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  // host write side
  logic                            host_wr_en;
  logic                            host_wr_sel;
  logic [ADDR_W-1:0]               host_wr_addr;
  logic [ARRAY_COL*DATA_WIDTH-1:0] host_wr_data;
  logic                            host_commit;
  logic                            host_wr_ready;
  logic                            tile_valid;

  // core streaming side
  logic                            ctrl_weight_load_en;
  logic                            ctrl_input_stream_en;
  logic                            ap_done;
  logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec;
  logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec;

  // error pulses
  logic                            wr_err;
  logic                            rd_err;

  modport master (
    output host_wr_en, host_wr_sel, host_wr_addr, host_wr_data, host_commit,
    output ctrl_weight_load_en, ctrl_input_stream_en, ap_done,
    input  host_wr_ready, tile_valid, in_weight_vec, in_act_vec, wr_err, rd_err
  );

  modport slave (
    input  host_wr_en, host_wr_sel, host_wr_addr, host_wr_data, host_commit,
    input  ctrl_weight_load_en, ctrl_input_stream_en, ap_done,
    output host_wr_ready, tile_valid, in_weight_vec, in_act_vec, wr_err, rd_err
  );
endinterface

// File: rtl/deit_tile_feeder.sv
// Double-buffered operand source for deit_core. The host fills the write bank
// while the core streams rows out of the read bank; ap_done hands the read bank
// back to the host. Each bank holds W_DEPTH weight rows and IN_DEPTH activation
// rows; both banks share one RAM per operand, addressed by {bank, row}.
module deit_tile_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_ROW  = 16,
  parameter int ARRAY_COL  = 16,
  parameter int W_DEPTH    = 12,
  parameter int IN_DEPTH   = 16
) (
  input  logic clk,
  input  logic rst,
  deit_tile_feeder_if.slave bus
);
  localparam int W_ROW_W   = ARRAY_COL * DATA_WIDTH;
  localparam int A_ROW_W   = ARRAY_ROW * DATA_WIDTH;
  localparam int MAX_DEPTH = (W_DEPTH > IN_DEPTH) ? W_DEPTH : IN_DEPTH;
  localparam int ADDR_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int LIM_W     = ADDR_W + 1;
  localparam int MEM_DEPTH = 2 * (2 ** ADDR_W);

  localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(W_DEPTH - 1);
  localparam logic [ADDR_W-1:0] IN_LAST = ADDR_W'(IN_DEPTH - 1);
  localparam logic [LIM_W-1:0]  W_LIM   = LIM_W'(W_DEPTH);
  localparam logic [LIM_W-1:0]  IN_LIM  = LIM_W'(IN_DEPTH);

  // bank bookkeeping
  logic [1:0]        full_reg;
  logic [1:0]        full_next;
  logic              wr_bank_reg;
  logic              rd_bank_reg;

  // stream pointers and registered outputs
  logic [ADDR_W-1:0] w_ptr_reg;
  logic [ADDR_W-1:0] in_ptr_reg;
  logic [W_ROW_W-1:0] weight_vec_reg;
  logic [A_ROW_W-1:0] act_vec_reg;
  logic              wr_err_reg;
  logic              rd_err_reg;

  // both banks of each operand live in one array; bank is the address MSB
  logic [W_ROW_W-1:0] wmem [MEM_DEPTH];
  logic [A_ROW_W-1:0] amem [MEM_DEPTH];

  logic              wr_ready;
  logic              rd_full;
  logic              addr_ok;
  logic              wr_accept;
  logic              commit_accept;
  logic              release_accept;
  logic              wr_err_next;
  logic              rd_err_next;
  logic              any_req;
  logic [ADDR_W:0]   wr_index;
  logic [ADDR_W:0]   w_rd_index;
  logic [ADDR_W:0]   a_rd_index;

  assign wr_ready = !full_reg[wr_bank_reg];
  assign rd_full  = full_reg[rd_bank_reg];

  // the row index must fit the memory it targets (weights are shallower)
  assign addr_ok = bus.host_wr_sel ? ({1'b0, bus.host_wr_addr} < IN_LIM)
                                   : ({1'b0, bus.host_wr_addr} < W_LIM);

  assign wr_accept      = bus.host_wr_en && wr_ready && addr_ok;
  assign commit_accept  = bus.host_commit && wr_ready;
  assign release_accept = bus.ap_done && rd_full;
  assign any_req        = bus.ctrl_weight_load_en || bus.ctrl_input_stream_en;

  assign wr_err_next = (bus.host_wr_en && !(wr_ready && addr_ok)) ||
                       (bus.host_commit && !wr_ready);
  assign rd_err_next = any_req && !rd_full;

  assign wr_index   = {wr_bank_reg, bus.host_wr_addr};
  assign w_rd_index = {rd_bank_reg, w_ptr_reg};
  assign a_rd_index = {rd_bank_reg, in_ptr_reg};

  // Per-bank full flag: a commit only ever sets an empty bank and a release
  // only clears a full one, so both can land on the same edge without conflict.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      assign full_next[gi] =
        (commit_accept  && (wr_bank_reg == 1'(gi))) ? 1'b1 :
        (release_accept && (rd_bank_reg == 1'(gi))) ? 1'b0 :
        full_reg[gi];
    end
  endgenerate

  // Host writes into the current write bank; RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      if (bus.host_wr_sel) begin
        amem[wr_index] <= A_ROW_W'(bus.host_wr_data);
      end else begin
        wmem[wr_index] <= bus.host_wr_data;
      end
    end
  end

  // Weight row register: loads while requested, otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_vec_reg <= '0;
    end else if (bus.ctrl_weight_load_en) begin
      weight_vec_reg <= wmem[w_rd_index];
    end
  end

  // Activation row register: zero when idle so the core sees skew padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_vec_reg <= '0;
    end else if (bus.ctrl_input_stream_en) begin
      act_vec_reg <= amem[a_rd_index];
    end else begin
      act_vec_reg <= '0;
    end
  end

  // Bank flags, bank pointers, stream pointers and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg    <= 2'b00;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      w_ptr_reg   <= '0;
      in_ptr_reg  <= '0;
      wr_err_reg  <= 1'b0;
      rd_err_reg  <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (commit_accept) begin
        wr_bank_reg <= !wr_bank_reg;
      end
      if (release_accept) begin
        rd_bank_reg <= !rd_bank_reg;
      end

      // pointers saturate on the last row so it repeats while still requested
      if (bus.ctrl_weight_load_en) begin
        if (w_ptr_reg != W_LAST) begin
          w_ptr_reg <= w_ptr_reg + 1'b1;
        end
      end else begin
        w_ptr_reg <= '0;
      end

      if (bus.ctrl_input_stream_en) begin
        if (in_ptr_reg != IN_LAST) begin
          in_ptr_reg <= in_ptr_reg + 1'b1;
        end
      end else begin
        in_ptr_reg <= '0;
      end

      wr_err_reg <= wr_err_next;
      rd_err_reg <= rd_err_next;
    end
  end

  assign bus.host_wr_ready = wr_ready;
  assign bus.tile_valid    = rd_full;
  assign bus.in_weight_vec = weight_vec_reg;
  assign bus.in_act_vec    = act_vec_reg;
  assign bus.wr_err        = wr_err_reg;
  assign bus.rd_err        = rd_err_reg;

endmodule

// File: tb/tb_deit_tile_feeder.sv
// Bench for deit_tile_feeder: directed walk through the tile flow with literal
// expectations, then random host/core traffic checked every cycle against a
// behavioural model of the two banks.
module tb_deit_tile_feeder;
  localparam int DW  = 8;
  localparam int AR  = 16;
  localparam int AC  = 16;
  localparam int WD  = 12;
  localparam int ID  = 16;
  localparam int RW  = AC * DW;

  logic clk;
  logic rst;

  deit_tile_feeder_if #(.DATA_WIDTH(DW), .ARRAY_ROW(AR), .ARRAY_COL(AC),
                        .W_DEPTH(WD), .IN_DEPTH(ID)) bus ();

  deit_tile_feeder #(.DATA_WIDTH(DW), .ARRAY_ROW(AR), .ARRAY_COL(AC),
                     .W_DEPTH(WD), .IN_DEPTH(ID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  // ---------------- behavioural model ----------------
  logic [RW-1:0] m_w [2][WD];
  logic [RW-1:0] m_a [2][ID];
  bit            m_wk [2][WD];
  bit            m_ak [2][ID];
  bit [1:0]      m_full;
  bit            m_wr, m_rd;
  int            m_wrun, m_arun;
  logic [RW-1:0] m_wvec, m_avec;
  bit            m_wok, m_aok;
  bit            m_werr, m_rerr;
  bit            m_init = 1'b0;

  bit t_ready, t_valid, t_inr, t_rel, t_owr, t_ord;
  int t_idx, t_addr;

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < WD; r++) m_wk[b][r] = 1'b0;
      for (int r = 0; r < ID; r++) m_ak[b][r] = 1'b0;
    end
  end

  // The model counts how long each request has been held; the row shown is
  // that count clamped to the last row of the tile.
  always @(posedge clk) begin
    if (rst) begin
      m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0;
      m_wrun = 0; m_arun = 0;
      m_wvec = '0; m_avec = '0; m_wok = 1'b1; m_aok = 1'b1;
      m_werr = 1'b0; m_rerr = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      t_ready = !m_full[m_wr];
      t_valid = m_full[m_rd];
      t_addr  = int'(bus.host_wr_addr);
      t_inr   = bus.host_wr_sel ? (t_addr < ID) : (t_addr < WD);
      m_werr  = (bus.host_wr_en && !(t_ready && t_inr)) || (bus.host_commit && !t_ready);
      m_rerr  = (bus.ctrl_weight_load_en || bus.ctrl_input_stream_en) && !t_valid;

      if (bus.ctrl_weight_load_en) begin
        t_idx  = (m_wrun < WD) ? m_wrun : WD - 1;
        m_wvec = m_w[m_rd][t_idx];
        m_wok  = m_wk[m_rd][t_idx];
        if (m_wrun < 1000) m_wrun++;
      end else begin
        m_wrun = 0;
      end

      if (bus.ctrl_input_stream_en) begin
        t_idx  = (m_arun < ID) ? m_arun : ID - 1;
        m_avec = m_a[m_rd][t_idx];
        m_aok  = m_ak[m_rd][t_idx];
        if (m_arun < 1000) m_arun++;
      end else begin
        m_arun = 0; m_avec = '0; m_aok = 1'b1;
      end

      if (bus.host_wr_en && t_ready && t_inr) begin
        if (bus.host_wr_sel) begin
          m_a[m_wr][t_addr] = bus.host_wr_data; m_ak[m_wr][t_addr] = 1'b1;
        end else begin
          m_w[m_wr][t_addr] = bus.host_wr_data; m_wk[m_wr][t_addr] = 1'b1;
        end
      end

      t_owr = m_wr;
      t_ord = m_rd;
      t_rel = bus.ap_done && m_full[t_ord];
      if (bus.host_commit && t_ready) begin
        m_full[t_owr] = 1'b1; m_wr = !m_wr;
      end
      if (t_rel) begin
        m_full[t_ord] = 1'b0; m_rd = !m_rd;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("host_wr_ready", RW'(bus.host_wr_ready), RW'(!m_full[m_wr]));
      chk("tile_valid",    RW'(bus.tile_valid),    RW'(m_full[m_rd]));
      chk("wr_err",        RW'(bus.wr_err),        RW'(m_werr));
      chk("rd_err",        RW'(bus.rd_err),        RW'(m_rerr));
      if (m_wok) chk("in_weight_vec", bus.in_weight_vec, m_wvec);
      if (m_aok) chk("in_act_vec",    bus.in_act_vec,    m_avec);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.host_wr_en = 1'b0; bus.host_wr_sel = 1'b0; bus.host_wr_addr = '0;
    bus.host_wr_data = '0; bus.host_commit = 1'b0;
    bus.ctrl_weight_load_en = 1'b0; bus.ctrl_input_stream_en = 1'b0;
    bus.ap_done = 1'b0;
  endtask

  task automatic host_write(input logic sel, input int addr, input logic [RW-1:0] data);
    bus.host_wr_en = 1'b1; bus.host_wr_sel = sel;
    bus.host_wr_addr = 4'(addr); bus.host_wr_data = data;
    step();
    bus.host_wr_en = 1'b0;
  endtask

  task automatic fill_tile(input logic [7:0] wbase, input logic [7:0] abase);
    for (int r = 0; r < WD; r++) host_write(1'b0, r, rep(wbase + 8'(r)));
    for (int r = 0; r < ID; r++) host_write(1'b1, r, rep(abase + 8'(r)));
    bus.host_commit = 1'b1;
    step();
    bus.host_commit = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset host_wr_ready", RW'(bus.host_wr_ready), RW'(1));
    chk("reset tile_valid",    RW'(bus.tile_valid),    RW'(0));
    chk("reset in_weight_vec", bus.in_weight_vec, '0);
    chk("reset in_act_vec",    bus.in_act_vec,    '0);
    $display("txn reset released");

    // bank0 fill and commit
    fill_tile(8'h00, 8'h10);
    chk("bank0 commit tile_valid",    RW'(bus.tile_valid),    RW'(1));
    chk("bank0 commit host_wr_ready", RW'(bus.host_wr_ready), RW'(1));
    $display("txn bank0 filled and committed");

    // weight stream with saturation on the last row
    bus.ctrl_weight_load_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("weight row %0d", i), bus.in_weight_vec, rep(8'((i < WD) ? i : WD - 1)));
    end
    bus.ctrl_weight_load_en = 1'b0;
    step();
    $display("txn weight stream 14 cycles");

    // activation stream then drop
    bus.ctrl_input_stream_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("act row %0d", i), bus.in_act_vec, rep(8'h10 + 8'(i)));
    end
    bus.ctrl_input_stream_en = 1'b0;
    step();
    chk("act zero after drop", bus.in_act_vec, '0);
    $display("txn activation stream 16 cycles");

    // ping-pong: fill bank1, both full
    fill_tile(8'h80, 8'hA0);
    chk("both full host_wr_ready", RW'(bus.host_wr_ready), RW'(0));
    host_write(1'b0, 0, rep(8'hEE));
    chk("write while full wr_err", RW'(bus.wr_err), RW'(1));
    step();
    chk("wr_err one cycle", RW'(bus.wr_err), RW'(0));
    bus.host_commit = 1'b1; step(); bus.host_commit = 1'b0;
    chk("commit while full wr_err", RW'(bus.wr_err), RW'(1));
    bus.ctrl_weight_load_en = 1'b1; step();
    chk("bank0 row0 unchanged", bus.in_weight_vec, rep(8'h00));
    bus.ctrl_weight_load_en = 1'b0; step();
    $display("txn ping-pong both banks full");

    bus.ap_done = 1'b1; step(); bus.ap_done = 1'b0;
    chk("release host_wr_ready", RW'(bus.host_wr_ready), RW'(1));
    chk("release tile_valid",    RW'(bus.tile_valid),    RW'(1));
    bus.ctrl_weight_load_en = 1'b1;
    step(); chk("bank1 weight row0", bus.in_weight_vec, rep(8'h80));
    step(); chk("bank1 weight row1", bus.in_weight_vec, rep(8'h81));
    bus.ctrl_weight_load_en = 1'b0; step();
    $display("txn release bank0, stream bank1");

    // simultaneous commit of bank1 and release of bank0
    bus.ap_done = 1'b1; step(); bus.ap_done = 1'b0;
    chk("all empty tile_valid", RW'(bus.tile_valid), RW'(0));
    bus.host_commit = 1'b1; step();
    bus.ap_done = 1'b1; step();
    bus.host_commit = 1'b0; bus.ap_done = 1'b0;
    chk("simul tile_valid",    RW'(bus.tile_valid),    RW'(1));
    chk("simul host_wr_ready", RW'(bus.host_wr_ready), RW'(1));
    bus.ctrl_input_stream_en = 1'b1; step();
    chk("simul reads bank1", bus.in_act_vec, rep(8'hA0));
    bus.ctrl_input_stream_en = 1'b0; step();
    $display("txn simultaneous commit and release");

    // request with no full bank
    bus.ap_done = 1'b1; step(); bus.ap_done = 1'b0;
    bus.ctrl_weight_load_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rd_err cycle %0d", i), RW'(bus.rd_err), RW'(1));
    end
    bus.ctrl_weight_load_en = 1'b0; step();
    chk("rd_err clears", RW'(bus.rd_err), RW'(0));
    $display("txn request without full bank");

    // address range per memory
    host_write(1'b1, 12, rep(8'h55));
    chk("act addr 12 legal", RW'(bus.wr_err), RW'(0));
    host_write(1'b0, 12, rep(8'h66));
    chk("weight addr 12 illegal", RW'(bus.wr_err), RW'(1));
    step();
    $display("txn address range errors");

    // reset mid-stream
    bus.host_commit = 1'b1; step(); bus.host_commit = 1'b0;
    bus.ctrl_weight_load_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step();
    chk("midrst in_weight_vec", bus.in_weight_vec, '0);
    chk("midrst in_act_vec",    bus.in_act_vec,    '0);
    chk("midrst tile_valid",    RW'(bus.tile_valid),    RW'(0));
    chk("midrst host_wr_ready", RW'(bus.host_wr_ready), RW'(1));
    chk("midrst rd_err",        RW'(bus.rd_err),        RW'(0));
    rst = 1'b0; bus.ctrl_weight_load_en = 1'b0; step();
    $display("txn reset mid-stream");

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus.host_wr_en   = ($urandom_range(0, 2) == 0);
      bus.host_wr_sel  = 1'($urandom_range(0, 1));
      bus.host_wr_addr = 4'($urandom_range(0, 15));
      bus.host_wr_data = {$urandom, $urandom, $urandom, $urandom};
      bus.host_commit  = ($urandom_range(0, 15) == 0);
      bus.ap_done      = ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 9) == 0) bus.ctrl_weight_load_en = !bus.ctrl_weight_load_en;
      if ($urandom_range(0, 9) == 0) bus.ctrl_input_stream_en = !bus.ctrl_input_stream_en;
      rst = ($urandom_range(0, 999) == 0);
      step();
      if ((c % 1000) == 999) $display("txn random cycles done %0d", c + 1);
    end
    rst = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
